// File: rtl/gtp_frame_rcv.sv
`default_nettype none
// -----------------------------------------------------------------------------
// gtp_frame_rcv : per-lane frame delimiter, length/checksum checker and payload streamer. Rev 1.0
// -----------------------------------------------------------------------------
module gtp_frame_rcv #(
    parameter int MAXLEN = 1024,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      rx_data,
    input  logic             rx_k,
    output logic [15:0]      dout,
    output logic             dout_valid,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic [3:0]       dout_tag,
    output logic             done,
    output logic             done_ok,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CSUM    = 2'd2;
    localparam logic [1:0] S_SKIP    = 2'd3;

    localparam logic [11:0]      MAXLEN_W = 12'(MAXLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]  state;
    logic [15:0] acc;
    logic [10:0] remain;
    logic        first;

    logic        is_hdr;
    logic [10:0] hdr_len;
    logic        len_ok;

    assign is_hdr  = !rx_k && rx_data[15];
    assign hdr_len = rx_data[10:0];
    assign len_ok  = (hdr_len != 11'd0) && ({1'b0, hdr_len} <= MAXLEN_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc        <= 16'd0;
            remain     <= 11'd0;
            first      <= 1'b0;
            dout       <= 16'd0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            dout_tag   <= 4'd0;
            done       <= 1'b0;
            done_ok    <= 1'b0;
            err_code   <= 2'd0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    // K words and stray data words (bit15=0) are ignored here
                    if (is_hdr) begin
                        if (len_ok) begin
                            dout_tag <= rx_data[14:11];
                            remain   <= hdr_len;
                            acc      <= rx_data;
                            first    <= 1'b1;
                            state    <= S_PAYLOAD;
                        end else begin
                            done     <= 1'b1;
                            done_ok  <= 1'b0;
                            err_code <= 2'd1;
                            err_cnt  <= err_cnt + CNT_ONE;
                            state    <= S_SKIP;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_k) begin
                        done     <= 1'b1;
                        done_ok  <= 1'b0;
                        err_code <= 2'd2;
                        err_cnt  <= err_cnt + CNT_ONE;
                        state    <= S_IDLE;
                    end else begin
                        dout       <= rx_data;
                        dout_valid <= 1'b1;
                        dout_sop   <= first;
                        dout_eop   <= (remain == 11'd1);
                        first      <= 1'b0;
                        acc        <= acc + rx_data;
                        remain     <= remain - 11'd1;
                        if (remain == 11'd1) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (rx_k) begin
                        done_ok  <= 1'b0;
                        err_code <= 2'd2;
                        err_cnt  <= err_cnt + CNT_ONE;
                    end else if (rx_data == acc) begin
                        done_ok   <= 1'b1;
                        err_code  <= 2'd0;
                        frame_cnt <= frame_cnt + CNT_ONE;
                    end else begin
                        done_ok  <= 1'b0;
                        err_code <= 2'd3;
                        err_cnt  <= err_cnt + CNT_ONE;
                    end
                end
                S_SKIP: begin
                    if (rx_k) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
